categorizer_arbiter: RTL and testbench
======================================

CATEGORIZER_ARBITER -- requirements
Module: categorizer_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters (2..8).
REQ-002 Parameter RSP_DEPTH, default 2, response FIFO entries (>=2).
REQ-003 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-004 RST  input  1  reset, synchronous, active-high.
REQ-005 REQ_VALID  input  N_REQ  per-requester operand valid.
REQ-006 REQ_F  input  N_REQ x 16  per-requester float16 operand.
REQ-007 REQ_READY  output  N_REQ  per-requester accept; at most one bit set.
REQ-008 RSP_VALID  output  1  response valid.
REQ-009 RSP_READY  input  1  consumer accept.
REQ-010 RSP_ID  output  clog2(N_REQ)  index of the requester that issued the operand.
REQ-011 RSP_TYPE  output  6  one-hot class: 5 normal, 4 subnormal, 3 zero, 2 infinity, 1 quiet NaN, 0 signalling NaN.
REQ-012 RSP_EXPONENT  output  7 signed  unbiased exponent, subnormals normalised.
REQ-013 RSP_SIGNIFICAND  output  11  significand with explicit leading one, left-normalised for subnormals.

Function
REQ-014 The block shall share one categorizer instance, built with its output register enabled (1-cycle latency), among N_REQ requesters.
REQ-015 The arbiter shall be round-robin: the search starts at pointer PTR; the first requester at or after PTR with REQ_VALID=1 receives REQ_READY=1.
REQ-016 REQ_READY may depend combinationally on REQ_VALID, PTR and credit; requesters shall not make REQ_VALID depend on REQ_READY.
REQ-017 A transfer occurs when REQ_VALID[i]&REQ_READY[i]; PTR shall then become (i+1) mod N_REQ at the next edge; PTR holds when there is no transfer.
REQ-018 Credit = RSP_DEPTH - fifo_count - inflight; all REQ_READY shall be 0 when credit is 0, so responses are never dropped.
REQ-019 A transfer in cycle t drives REQ_F[i] into the categorizer; its ID travels in a matching 1-stage valid/ID pipeline; the result is written to the FIFO at the end of cycle t+1.
REQ-020 With the FIFO empty and RSP_READY=1, RSP_VALID shall assert in cycle t+2 (2-cycle latency).
REQ-021 The FIFO shall be first-word-fall-through; RSP_* fields shall remain stable while RSP_VALID=1 and RSP_READY=0.
REQ-022 A simultaneous FIFO write and read shall be legal at any fill level, including full, with no loss and no duplication.
REQ-023 Responses shall leave in transfer order, and RSP_ID shall match the issuing requester.
REQ-024 Sustained throughput shall be one operand per cycle when RSP_READY stays 1 and RSP_DEPTH >= 2.
REQ-025 Pointer wrap: after a grant to N_REQ-1, PTR shall become 0.
REQ-026 Field encoding shall equal the categorizer's output for the same F; zero reports EXPONENT=-24 and SIGNIFICAND=0.

Reset
REQ-027 While RST=1 at a posedge: PTR=0, the FIFO is emptied, the in-flight valid bit is cleared, and RSP_VALID=0 from the next cycle.
REQ-028 During reset, REQ_READY shall be 0 and RSP_ID/TYPE/EXPONENT/SIGNIFICAND shall be 0.
REQ-029 Reset mid-operation shall discard in-flight and queued results; no response from before reset shall appear afterwards.

Structure
REQ-030 Package fp16_pkg shall hold the TYPE bit-index constants (TYPE_NORMAL=5 .. TYPE_NANS=0), the 6-bit type typedef and the EXP_W=7 / SIG_W=11 constants.
REQ-031 The response queue shall be one sub-module, cat_rsp_fifo (parameterised width and depth, synchronous active-high reset).
REQ-032 The arbiter, credit counter and ID pipeline shall reside in categorizer_arbiter; the categorizer shall be instantiated, not duplicated.

Verification
REQ-033 Req0 F=0x3C00, RSP_READY=1 -> RSP_VALID 2 cycles later, ID=0, TYPE=100000, EXP=0, SIG=0x400.
REQ-034 All 4 requesters valid every cycle (F=0x0001, 0x7C00, 0x7E00, 0x7C01), RSP_READY=1 -> grants 0,1,2,3,0; TYPE 010000 (EXP=-24, SIG=0x400), 000100, 000010, 000001; one response per cycle.
REQ-035 RSP_READY=0 with req1 valid continuously -> exactly RSP_DEPTH transfers, then REQ_READY=0; on RSP_READY=1 the queued results drain in order and transfers resume.
REQ-036 FIFO full with RSP_READY=1 and a new transfer in the same cycle -> count stays at RSP_DEPTH, no lost or duplicated ID.
REQ-037 RST asserted for 1 cycle with 2 results queued and 1 in flight -> RSP_VALID=0 next cycle, PTR=0, no stale responses afterwards.
REQ-038 F=0x0000 from req3 only -> ID=3, TYPE=001000, EXP=-24, SIG=0; PTR becomes 0.

Source files
------------

// File: rtl/fp16_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fp16_pkg
// Purpose  : Shared float16 classification constants and types.
// Revision : 1.0
// ============================================================================
package fp16_pkg;

  // Bit positions inside the one-hot class vector
  localparam int TYPE_NORMAL    = 5;
  localparam int TYPE_SUBNORMAL = 4;
  localparam int TYPE_ZERO      = 3;
  localparam int TYPE_INF       = 2;
  localparam int TYPE_NANQ      = 1;
  localparam int TYPE_NANS      = 0;

  localparam int TYPE_W = 6;
  localparam int EXP_W  = 7;
  localparam int SIG_W  = 11;

  typedef logic [TYPE_W-1:0] fp_type_t;

  function automatic fp_type_t type_bit(input int idx);
    return fp_type_t'(1) << idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cat_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : cat_rsp_fifo
// Purpose  : First-word-fall-through response queue; write+read legal when full.
// Revision : 1.0
// ============================================================================
module cat_rsp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 2,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             valid,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_push;
  logic             w_pop;

  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign w_pop  = rd_en && (r_count != '0);
  // A full queue still accepts a write when the head leaves in the same cycle
  assign w_push = wr_en && ((r_count != CW'(DEPTH)) || w_pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
      if (w_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= wr_data;
  end

  assign valid   = (r_count != '0);
  assign rd_data = valid ? r_mem[r_rd_ptr] : '0;
  assign count   = r_count;

endmodule
`default_nettype wire

// File: rtl/fp16_categorizer.sv
`default_nettype none
// ============================================================================
// Module   : fp16_categorizer
// Purpose  : Classifies a float16 and returns unbiased exponent/significand.
// Revision : 1.0
// ============================================================================
module fp16_categorizer
  import fp16_pkg::*;
#(
  parameter int OUT_REG = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [15:0]             f,
  output fp_type_t                cls,
  output logic signed [EXP_W-1:0] exponent,
  output logic [SIG_W-1:0]        significand
);

  localparam logic signed [EXP_W-1:0] C_MIN_EXP = -7'sd24;

  logic [4:0]              w_efield;
  logic [9:0]              w_man;
  logic [3:0]              w_lead;
  fp_type_t                w_cls;
  logic signed [EXP_W-1:0] w_exp;
  logic [SIG_W-1:0]        w_sig;
  logic                    w_unused_sign;

  assign w_efield      = f[14:10];
  assign w_man         = f[9:0];
  assign w_unused_sign = f[15];

  always_comb begin
    w_lead = '0;
    for (int b = 0; b < 10; b++) begin
      if (w_man[b]) w_lead = 4'(b);
    end
  end

  always_comb begin
    w_cls = '0;
    w_exp = $signed({2'b00, w_efield}) - 7'sd15;
    w_sig = {1'b1, w_man};
    if (w_efield == 5'h1f) begin
      if (w_man == '0)   w_cls = type_bit(TYPE_INF);
      else if (w_man[9]) w_cls = type_bit(TYPE_NANQ);
      else               w_cls = type_bit(TYPE_NANS);
    end else if (w_efield == 5'h00) begin
      if (w_man == '0) begin
        w_cls = type_bit(TYPE_ZERO);
        w_exp = C_MIN_EXP;
        w_sig = '0;
      end else begin
        // Shift the leading one up to bit 10 and credit the exponent
        w_cls = type_bit(TYPE_SUBNORMAL);
        w_exp = C_MIN_EXP + $signed({3'b000, w_lead});
        w_sig = {1'b0, w_man} << (4'd10 - w_lead);
      end
    end else begin
      w_cls = type_bit(TYPE_NORMAL);
    end
  end

  if (OUT_REG != 0) begin : g_out_reg
    always_ff @(posedge clk) begin
      if (rst) begin
        cls         <= '0;
        exponent    <= '0;
        significand <= '0;
      end else begin
        cls         <= w_cls;
        exponent    <= w_exp;
        significand <= w_sig;
      end
    end
  end else begin : g_out_comb
    assign cls         = w_cls;
    assign exponent    = w_exp;
    assign significand = w_sig;
  end

endmodule
`default_nettype wire

// File: rtl/categorizer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : categorizer_arbiter
// Purpose  : Round-robin sharing of one float16 categorizer with credit-based
//            response queueing.
// Revision : 1.0
// ============================================================================
module categorizer_arbiter
  import fp16_pkg::*;
#(
  parameter  int N_REQ     = 4,
  parameter  int RSP_DEPTH = 2,
  localparam int ID_W      = $clog2(N_REQ)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req_valid,
  input  logic [N_REQ-1:0][15:0]  req_f,
  output logic [N_REQ-1:0]        req_ready,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output fp_type_t                rsp_type,
  output logic signed [EXP_W-1:0] rsp_exponent,
  output logic [SIG_W-1:0]        rsp_significand
);

  localparam int DW = ID_W + TYPE_W + EXP_W + SIG_W;
  localparam int CW = $clog2(RSP_DEPTH + 1);

  logic [ID_W-1:0]         r_ptr;
  logic                    r_pipe_valid;
  logic [ID_W-1:0]         r_pipe_id;
  logic [ID_W:0]           w_slot;
  logic                    w_found;
  logic [ID_W-1:0]         w_grant_idx;
  logic                    w_credit_ok;
  logic                    w_xfer;
  logic                    w_pop;
  logic [15:0]             w_f;
  fp_type_t                w_cat_type;
  logic signed [EXP_W-1:0] w_cat_exp;
  logic [SIG_W-1:0]        w_cat_sig;
  logic [DW-1:0]           w_rd_data;
  logic                    w_fifo_valid;
  logic [CW-1:0]           w_fifo_count;

  always_comb begin
    w_found     = 1'b0;
    w_grant_idx = '0;
    w_slot      = '0;
    for (int k = 0; k < N_REQ; k++) begin
      w_slot = {1'b0, r_ptr} + (ID_W+1)'(k);
      if (w_slot >= (ID_W+1)'(N_REQ)) w_slot = w_slot - (ID_W+1)'(N_REQ);
      if (!w_found && req_valid[w_slot[ID_W-1:0]]) begin
        w_found     = 1'b1;
        w_grant_idx = w_slot[ID_W-1:0];
      end
    end
  end

  // A head leaving this cycle frees a slot in time for the new result,
  // which keeps one operand per cycle flowing with only two entries
  assign w_pop       = rsp_valid && rsp_ready;
  assign w_credit_ok = (32'(w_fifo_count) + 32'(r_pipe_valid)) <
                       (32'(RSP_DEPTH) + 32'(w_pop));
  assign w_xfer      = w_found && w_credit_ok && !rst;

  always_comb begin
    req_ready = '0;
    if (w_xfer) req_ready[w_grant_idx] = 1'b1;
  end

  assign w_f = req_f[w_grant_idx];

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr        <= '0;
      r_pipe_valid <= 1'b0;
      r_pipe_id    <= '0;
    end else begin
      r_pipe_valid <= w_xfer;
      r_pipe_id    <= w_grant_idx;
      if (w_xfer) begin
        r_ptr <= (w_grant_idx == ID_W'(N_REQ - 1)) ? '0 : w_grant_idx + 1'b1;
      end
    end
  end

  fp16_categorizer #(
    .OUT_REG (1)
  ) u_cat (
    .clk         (clk),
    .rst         (rst),
    .f           (w_f),
    .cls         (w_cat_type),
    .exponent    (w_cat_exp),
    .significand (w_cat_sig)
  );

  cat_rsp_fifo #(
    .WIDTH (DW),
    .DEPTH (RSP_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (r_pipe_valid),
    .wr_data ({r_pipe_id, w_cat_type, w_cat_exp, w_cat_sig}),
    .rd_en   (w_pop),
    .rd_data (w_rd_data),
    .valid   (w_fifo_valid),
    .count   (w_fifo_count)
  );

  assign rsp_valid = w_fifo_valid && !rst;
  assign {rsp_id, rsp_type, rsp_exponent, rsp_significand} = rst ? '0 : w_rd_data;

endmodule
`default_nettype wire

// File: tb/tb_categorizer_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_categorizer_arbiter
// Purpose  : Directed self-checking bench for categorizer_arbiter.
// Revision : 1.0
// ============================================================================
module tb_categorizer_arbiter;
  import fp16_pkg::*;

  localparam int N = 4;
  localparam int D = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic [N-1:0]            req_valid;
  logic [N-1:0][15:0]      req_f;
  logic [N-1:0]            req_ready;
  logic                    rsp_valid;
  logic                    rsp_ready;
  logic [1:0]              rsp_id;
  fp_type_t                rsp_type;
  logic signed [EXP_W-1:0] rsp_exponent;
  logic [SIG_W-1:0]        rsp_significand;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  categorizer_arbiter #(
    .N_REQ     (N),
    .RSP_DEPTH (D)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .req_valid       (req_valid),
    .req_f           (req_f),
    .req_ready       (req_ready),
    .rsp_valid       (rsp_valid),
    .rsp_ready       (rsp_ready),
    .rsp_id          (rsp_id),
    .rsp_type        (rsp_type),
    .rsp_exponent    (rsp_exponent),
    .rsp_significand (rsp_significand)
  );

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] expv);
    total++;
    assert (obs === expv) passed++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
  endtask

  task automatic chk_cls(input string tag, input int id, input logic [5:0] ty);
    check({tag, ".valid"}, rsp_valid, 1);
    check({tag, ".id"}, rsp_id, id);
    check({tag, ".type"}, rsp_type, ty);
  endtask

  task automatic chk_rsp(input string tag, input int id, input logic [5:0] ty,
                         input int ex, input int sg);
    chk_cls(tag, id, ty);
    check({tag, ".exp"}, rsp_exponent, ex);
    check({tag, ".sig"}, rsp_significand, sg);
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    req_valid = '1;
    req_f     = '0;
    rsp_ready = 1'b1;

    // Reset state
    nxt(); nxt(); #1;
    check("rst.ready", req_ready, 0);
    check("rst.valid", rsp_valid, 0);
    check("rst.fields", {rsp_id, rsp_type, rsp_exponent, rsp_significand}, 0);

    // All four requesters busy: round-robin at full rate
    nxt();
    rst = 1'b0; req_valid = 4'b1111;
    req_f[0] = 16'h0001; req_f[1] = 16'h7C00; req_f[2] = 16'h7E00; req_f[3] = 16'h7C01;
    #1;
    check("rr.grant0", req_ready, 4'b0001);
    check("rr.idle0", rsp_valid, 0);
    nxt(); #1;
    check("rr.grant1", req_ready, 4'b0010);
    check("rr.idle1", rsp_valid, 0);
    nxt(); #1;
    check("rr.grant2", req_ready, 4'b0100);
    chk_rsp("rr.rsp0", 0, 6'b010000, -24, 'h400);
    nxt(); #1;
    check("rr.grant3", req_ready, 4'b1000);
    chk_cls("rr.rsp1", 1, 6'b000100);
    nxt(); #1;
    check("rr.grant_wrap", req_ready, 4'b0001);
    chk_cls("rr.rsp2", 2, 6'b000010);
    nxt(); req_valid = '0; #1;
    check("rr.no_grant", req_ready, 0);
    chk_cls("rr.rsp3", 3, 6'b000001);
    nxt(); #1;
    chk_rsp("rr.rsp4", 0, 6'b010000, -24, 'h400);
    nxt(); #1;
    check("rr.drained", rsp_valid, 0);

    // Single normal operand: two-cycle latency
    nxt(); req_valid = 4'b0001; req_f[0] = 16'h3C00; #1;
    check("one.grant", req_ready, 4'b0001);
    nxt(); req_valid = '0; #1;
    check("one.t1", rsp_valid, 0);
    nxt(); #1;
    chk_rsp("one.rsp", 0, 6'b100000, 0, 'h400);
    nxt(); #1;
    check("one.after", rsp_valid, 0);

    // Backpressure: exactly D transfers, then drain in order and resume
    nxt(); rsp_ready = 1'b0; req_valid = 4'b0010; req_f[1] = 16'h4000; #1;
    check("bp.grant_a", req_ready, 4'b0010);
    nxt(); req_f[1] = 16'h4200; #1;
    check("bp.grant_b", req_ready, 4'b0010);
    nxt(); req_f[1] = 16'h4400; #1;
    check("bp.grant_c", req_ready, 4'b0010);
    chk_rsp("bp.head", 1, 6'b100000, 1, 'h400);
    nxt(); req_f[1] = 16'h4500; #1;
    check("bp.blocked0", req_ready, 0);
    nxt(); #1;
    check("bp.blocked1", req_ready, 0);
    chk_rsp("bp.stable", 1, 6'b100000, 1, 'h400);
    nxt(); rsp_ready = 1'b1; #1;
    check("bp.full_rw_grant", req_ready, 4'b0010);
    chk_rsp("bp.rsp_a", 1, 6'b100000, 1, 'h400);
    nxt(); req_valid = '0; #1;
    chk_rsp("bp.rsp_b", 1, 6'b100000, 1, 'h600);
    nxt(); #1;
    chk_rsp("bp.rsp_c", 1, 6'b100000, 2, 'h400);
    nxt(); #1;
    chk_rsp("bp.rsp_d", 1, 6'b100000, 2, 'h500);
    nxt(); #1;
    check("bp.drained", rsp_valid, 0);

    // Reset with two queued results and one in flight
    nxt(); rsp_ready = 1'b0; req_valid = 4'b0100; req_f[2] = 16'h3C00; #1;
    check("mr.grant0", req_ready, 4'b0100);
    nxt(); #1;
    nxt(); #1;
    check("mr.grant2", req_ready, 4'b0100);
    nxt(); rst = 1'b1; req_valid = 4'b1111; #1;
    check("mr.rst_ready", req_ready, 0);
    check("mr.rst_valid", rsp_valid, 0);
    check("mr.rst_fields", {rsp_id, rsp_type, rsp_exponent, rsp_significand}, 0);
    nxt(); rst = 1'b0; req_valid = '0; rsp_ready = 1'b1; #1;
    check("mr.no_stale0", rsp_valid, 0);
    nxt(); req_valid = 4'b1001; req_f[0] = 16'h0200; req_f[3] = 16'h0000; #1;
    check("mr.no_stale1", rsp_valid, 0);
    check("mr.ptr_zero", req_ready, 4'b0001);
    nxt(); req_valid = '0; #1;
    check("mr.no_stale2", rsp_valid, 0);
    nxt(); #1;
    chk_rsp("mr.rsp", 0, 6'b010000, -15, 'h400);
    nxt(); #1;
    check("mr.drained", rsp_valid, 0);

    // Zero from the last requester; pointer wraps to 0
    nxt(); req_valid = 4'b1000; #1;
    check("z.grant3", req_ready, 4'b1000);
    nxt(); req_valid = '0; #1;
    nxt(); #1;
    chk_rsp("z.rsp", 3, 6'b001000, -24, 0);
    nxt(); req_valid = 4'b1111; #1;
    check("z.ptr_wrap", req_ready, 4'b0001);
    nxt(); req_valid = '0; #1;
    nxt(); #1;
    chk_rsp("z.rsp_after", 0, 6'b010000, -15, 'h400);
    nxt(); #1;
    check("z.drained", rsp_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
